// File: rtl/fb_swap_ctrl.sv
// Double-buffered frame buffer controller: PPU raster writes go to the back buffer,
// display reads come from the front buffer, and the two swap on vsync once a back frame is complete.
module fb_swap_ctrl #(
  parameter int H_PIX     = 160,
  parameter int V_PIX     = 144,
  parameter int BUF_WORDS = H_PIX * V_PIX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid_in,
  input  logic        pix_sof_in,
  input  logic [14:0] pix_data_in,
  output logic        pix_ready_out,
  input  logic        rd_req_in,
  input  logic [7:0]  rd_x_in,
  input  logic [7:0]  rd_y_in,
  output logic        rd_valid_out,
  output logic [14:0] rd_data_out,
  input  logic        vsync_in,
  output logic        swap_out,
  output logic        front_sel_out,
  output logic        fb_ena,
  output logic        fb_wea,
  output logic [15:0] fb_addra,
  output logic [14:0] fb_dina,
  output logic        fb_enb,
  output logic        fb_web,
  output logic [15:0] fb_addrb,
  input  logic [14:0] fb_doutb
);

  typedef enum logic {FILL = 1'b0, WAIT_SWAP = 1'b1} state_t;

  localparam logic [15:0] BUF_BASE  = 16'(BUF_WORDS);
  localparam logic [15:0] LAST_OFFS = 16'(BUF_WORDS - 1);
  localparam logic [15:0] H_LIM     = 16'(H_PIX);
  localparam logic [15:0] V_LIM     = 16'(V_PIX);

  state_t      state_reg;
  logic [15:0] wr_cnt_reg;
  logic        front_sel_reg;
  logic        rd_req1_reg;
  logic        rd_inr1_reg;
  logic        rd_inr2_reg;

  logic        accept;
  logic [15:0] offset;
  logic [15:0] back_base;
  logic [15:0] front_base;
  logic [15:0] x16;
  logic [15:0] y16;
  logic [15:0] rd_addr;
  logic        rd_in_range;
  logic        rd_hit;

  always_comb begin
    accept      = pix_valid_in && (state_reg == FILL);
    offset      = pix_sof_in ? 16'd0 : wr_cnt_reg;
    back_base   = front_sel_reg ? 16'd0 : BUF_BASE;
    front_base  = front_sel_reg ? BUF_BASE : 16'd0;
    x16         = {8'd0, rd_x_in};
    y16         = {8'd0, rd_y_in};
    // y*160 built from shifts; the front buffer tops out at address 46079
    rd_addr     = front_base + (y16 << 7) + (y16 << 5) + x16;
    rd_in_range = (x16 < H_LIM) && (y16 < V_LIM);
    rd_hit      = rd_req_in && rd_in_range;
  end

  assign pix_ready_out = (state_reg == FILL);
  assign front_sel_out = front_sel_reg;
  assign fb_web        = 1'b0;
  assign rd_data_out   = rd_inr2_reg ? fb_doutb : 15'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      wr_cnt_reg    <= 16'd0;
      front_sel_reg <= 1'b0;
      swap_out      <= 1'b0;
      fb_ena        <= 1'b0;
      fb_wea        <= 1'b0;
      fb_addra      <= 16'd0;
      fb_dina       <= 15'd0;
      fb_enb        <= 1'b0;
      fb_addrb      <= 16'd0;
      rd_req1_reg   <= 1'b0;
      rd_inr1_reg   <= 1'b0;
      rd_inr2_reg   <= 1'b0;
      rd_valid_out  <= 1'b0;
    end else begin
      fb_ena   <= accept;
      fb_wea   <= accept;
      fb_addra <= accept ? (back_base + offset) : 16'd0;
      fb_dina  <= accept ? pix_data_in : 15'd0;
      swap_out <= 1'b0;

      case (state_reg)
        FILL: begin
          if (accept) begin
            if (offset == LAST_OFFS) begin
              wr_cnt_reg <= 16'd0;
              state_reg  <= WAIT_SWAP;
            end else begin
              wr_cnt_reg <= offset + 16'd1;
            end
          end
        end
        WAIT_SWAP: begin
          if (vsync_in) begin
            front_sel_reg <= ~front_sel_reg;
            swap_out      <= 1'b1;
            state_reg     <= FILL;
          end
        end
      endcase

      // Out-of-range requests still travel the pipeline so every request gets a response
      fb_enb       <= rd_hit;
      fb_addrb     <= rd_hit ? rd_addr : 16'd0;
      rd_req1_reg  <= rd_req_in;
      rd_inr1_reg  <= rd_hit;
      rd_valid_out <= rd_req1_reg;
      rd_inr2_reg  <= rd_inr1_reg;
    end
  end

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Double-buffer controller for the dual-port frame buffer RAM, placed between the PPU pixel stream and the display scan-out logic. The PPU writes RGB555 pixels in raster order into the back buffer through RAM port A. The display reads pixels by (x, y) from the front buffer through RAM port B. On the first display vsync after a complete back frame, the controller swaps the two buffers, so scan-out never shows a partially drawn frame.

## Interface
Parameters:
- H_PIX, 160, pixels per line
- V_PIX, 144, lines per frame
- BUF_WORDS, H_PIX*V_PIX (23040), words per buffer; buffer 0 at base 0, buffer 1 at base BUF_WORDS

Ports:
- clk  in  1  single clock for the whole block and both RAM ports
- rst_n  in  1  synchronous, active-low reset
- pix_valid_in  in  1  PPU pixel valid
- pix_sof_in  in  1  start of frame, qualifies the current pixel
- pix_data_in  in  15  RGB555 pixel
- pix_ready_out  out  1  controller can accept a pixel
- rd_req_in  in  1  display read request
- rd_x_in  in  8  column
- rd_y_in  in  8  line
- rd_valid_out  out  1  read data valid
- rd_data_out  out  15  read pixel
- vsync_in  in  1  one-cycle pulse from display at the start of vblank
- swap_out  out  1  one-cycle pulse when the buffers swap
- front_sel_out  out  1  index of the buffer currently being displayed
- fb_ena, fb_wea  out  1  RAM port A enable and write enable
- fb_addra  out  16  RAM port A address
- fb_dina  out  15  RAM port A write data
- fb_enb, fb_web  out  1  RAM port B enable and write enable; fb_web is tied to 0
- fb_addrb  out  16  RAM port B address
- fb_doutb  in  15  RAM port B read data, registered by the RAM one cycle after address

## Operation
- Write-side FSM states:
  - FILL: pix_ready_out=1.
  - WAIT_SWAP: pix_ready_out=0.
  - pix_ready_out decodes registered state only, with no combinational path from inputs.
- Accept condition: pix_valid_in & pix_ready_out.
- Write offset:
  - On accept, offset = pix_sof_in ? 0 : wr_cnt.
  - wr_cnt then becomes offset+1.
  - Write address = back_base + offset, where back_base = front_sel ? 0 : BUF_WORDS.
- Frame completion: when an accepted pixel has offset == BUF_WORDS-1, wr_cnt goes to 0 and the state goes to WAIT_SWAP.
- Resync: pix_sof_in mid-frame discards the partial frame and restarts at offset 0.
- Swap: in WAIT_SWAP with vsync_in=1:
  - front_sel toggles.
  - swap_out pulses.
  - State returns to FILL.
  - vsync_in is ignored while in FILL.
- Read address: rd_addr = front_base + rd_y_in*160 + rd_x_in.
  - Multiplication is done as (y<<7)+(y<<5), 16-bit unsigned.
  - front_base = front_sel ? BUF_WORDS : 0.
  - Maximum address is 46079.
- Out-of-range reads: a request with rd_x_in ≥ H_PIX or rd_y_in ≥ V_PIX does not enable port B. It still returns rd_valid_out with rd_data_out = 0.
- rd_data_out = fb_doutb when the returning request was in range, else 0. This is a combinational mux on a registered flag.

## Timing
- Reset values:
  - State FILL, wr_cnt 0, front_sel 0, hence back buffer 1.
  - All fb_* outputs 0, rd_valid_out 0, swap_out 0.
  - Reset mid-frame discards the partial frame; buffer contents are untouched.
- Write latency: a pixel accepted at edge N drives fb_ena=fb_wea=1 with fb_addra and fb_dina registered during cycle N+1. Port A outputs are 0 when there is no accept.
- Read latency:
  - rd_req_in sampled at edge N drives fb_enb and fb_addrb during cycle N+1.
  - The RAM returns data after edge N+2.
  - rd_valid_out=1 during cycle N+2, exactly 2 cycles after the request, one cycle wide per request.
  - Fully pipelined: one request per cycle.
- Swap timing: swap at edge S updates front_sel_out in cycle S+1.
  - A read sampled at edge S uses the old front_sel.
  - A write accepted at edge S+1 uses the new back_base.
- Last pixel and vsync in the same cycle: the state is still FILL at that edge, so the swap waits for the next vsync.
- The last pixel's RAM write (cycle N+1) always precedes any read of the new front buffer, which is issued at the earliest in cycle N+2.

## Test plan
- Reset, then stream 23040 pixels with data = offset[14:0]:
  - Port A addresses run 23040..46079.
  - pix_ready_out drops after the last accept.
  - front_sel_out stays 0 until vsync.
- WAIT_SWAP, then vsync_in pulse:
  - swap_out is one cycle.
  - front_sel_out=1.
  - A read of (159,143) gives fb_addrb=23039+23040=46079 and rd_valid_out two cycles after the request.
- Back-to-back reads (0,0), (1,0), (0,1) with front_sel=0:
  - fb_addrb = 0, 1, 160 on consecutive cycles.
  - rd_valid_out high for 3 consecutive cycles.
  - rd_data_out equals the RAM model data.
- Read of (160,0) and (0,144):
  - fb_enb stays 0.
  - rd_valid_out=1 with rd_data_out=0.
- pix_sof_in at offset 500:
  - The next write goes to back_base+0.
  - A full frame then requires 23040 further pixels before WAIT_SWAP.
  - vsync_in during FILL causes no swap.
- Last pixel accepted in the same cycle as vsync_in:
  - No swap at that vsync.
  - Swap at the next vsync_in.
  - rst_n=0 mid-stream returns all outputs to their reset values at the next edge.
